dpll_phase_filter: RTL
======================

// Module: dpll_phase_filter
// PURPOSE
//  Phase/frequency detector plus proportional-integral loop filter for the digital PLL.
//  Compares rising edges of an external reference against the DCO output (signal_out).
//  Produces the DCO tuning word speed_var, closing the loop.
//  Sits directly upstream of the DCO; dco_in is the DCO signal_out, fed back in the same clk domain.
// PARAMETERS
//  BIT_COUNT   24        width of speed_var / nominal / limits (matches DCO bit_count)
//  ERR_W       16        signed phase-error width; count saturates at 2^(ERR_W-1)-1
//  KP_SHIFT    2         proportional gain = err >>> KP_SHIFT (arithmetic)
//  KI_SHIFT    6         integral gain = err >>> KI_SHIFT, accumulated
//  SPEED_MIN   1         lower clamp of speed_var
//  SPEED_MAX   2^24-1    upper clamp of speed_var
//  LOCK_TOL    4         |err| <= LOCK_TOL counts as in-phase
//  LOCK_COUNT  16        consecutive in-phase updates required to assert lock
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  ref_in      in   1          reference clock, asynchronous to clk
//  dco_in      in   1          DCO signal_out, synchronous to clk
//  nominal     in   BIT_COUNT  free-running tuning word (integrator offset)
//  enable      in   1          0: hold speed_var = clamp(nominal), clear integrator, no updates
//  speed_var   out  BIT_COUNT  tuning word to DCO (registered)
//  phase_err   out  ERR_W      last measured signed error in clk cycles (registered)
//  err_valid   out  1          1-cycle pulse when phase_err updates
//  locked      out  1          lock indicator
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - speed_var=clamp(nominal) sampled at first clk after release; 0 while in reset.
//   - phase_err=0, err_valid=0, locked=0, integrator=0, FSM=IDLE.
//  Edges:
//   - ref_in through 2-flop synchroniser; ref_rise = s2 & ~s3.
//   - dco_in registered once; dco_rise = dco_in & ~dco_q.
//  FSM:
//   - IDLE:
//     . both rises same cycle -> err=0, measure.
//     . ref_rise only -> REF_LEAD, cnt=1.
//     . dco_rise only -> DCO_LEAD, cnt=1.
//   - REF_LEAD:
//     . dco_rise -> err=+cnt, IDLE.
//     . another ref_rise first -> err=+cnt, cnt=1, stay (cycle slip; DCO slow).
//     . else cnt++ saturating at ERR_MAX.
//   - DCO_LEAD: mirror of REF_LEAD; err=-cnt; repeated dco_rise -> err=-cnt, cnt=1, stay.
//   - A closing edge ends the measurement. phase_err/err_valid are registered the cycle after the closing edge is detected.
//  Filter: updates in the cycle after err_valid (speed_var latency = 2 clk from the detected closing edge).
//   - integ <= sat(integ + (err>>>KI_SHIFT)); integrator is signed BIT_COUNT+2 bits, saturating.
//   - speed_var <= clamp(nominal + integ + (err>>>KP_SHIFT), SPEED_MIN, SPEED_MAX).
//   - The sum is computed at BIT_COUNT+3 bits signed, so nothing wraps.
//   - Anti-windup: if the clamp is active and err pushes further out, integ holds.
//  Lock:
//   - Counter of consecutive updates with |err| <= LOCK_TOL.
//   - locked=1 when the counter reaches LOCK_COUNT; cleared on the first update with |err| > LOCK_TOL.
//   - The counter saturates.
//  enable=0:
//   - FSM forced to IDLE, integ=0, locked=0, err_valid=0.
//   - speed_var=clamp(nominal) next cycle; phase_err holds.
//  Reset mid-measurement discards cnt; there are no partial updates.
// TESTING
//  1. Reset, nominal=1000, enable=0 -> speed_var=1000, locked=0, err_valid never pulses.
//  2. ref_rise and dco_rise same cycle -> phase_err=0, err_valid pulse, speed_var unchanged (integ=0).
//  3. dco_rise 8 clk after ref_rise, KP=2, KI=6, nominal=1000 -> phase_err=+8, speed_var=1002, integ=0.
//  4. DCO leads by 200 clk repeatedly, KI=6 -> each update: phase_err=-200, integ -= 4 (>>>6 = -4); speed_var clamps at SPEED_MIN, then holds.
//  5. 16 updates with |err|<=4 -> locked=1 on the 16th; next err=+5 -> locked=0.
//  6. ref toggling, DCO stuck low -> cnt saturates at 32767; second ref_rise yields phase_err=+cnt (slip) without wrap.

Source files
------------

// File: rtl/dpll_phase_filter_if.sv
// Control/status bundle between the DPLL phase filter and its environment.
// The filter takes the slave side; stimulus or the surrounding PLL takes the master side.
interface dpll_phase_filter_if #(
    parameter int BIT_COUNT = 24,
    parameter int ERR_W     = 16
);
    logic                        ref_in;
    logic                        dco_in;
    logic [BIT_COUNT-1:0]        nominal;
    logic                        enable;
    logic [BIT_COUNT-1:0]        speed_var;
    logic signed [ERR_W-1:0]     phase_err;
    logic                        err_valid;
    logic                        locked;

    modport master (
        output ref_in, dco_in, nominal, enable,
        input  speed_var, phase_err, err_valid, locked
    );

    modport slave (
        input  ref_in, dco_in, nominal, enable,
        output speed_var, phase_err, err_valid, locked
    );
endinterface

// File: rtl/dpll_phase_filter.sv
// Phase/frequency detector and PI loop filter producing the DCO tuning word.
// Measures ref_in vs dco_in rising-edge offset in clk cycles, then updates speed_var.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | waiting for the first rising edge of a measurement
//  REF_LEAD | reference edge seen first, counting until the DCO edge
//  DCO_LEAD | DCO edge seen first, counting until the reference edge
module dpll_phase_filter #(
    parameter int                   BIT_COUNT  = 24,
    parameter int                   ERR_W      = 16,
    parameter int                   KP_SHIFT   = 2,
    parameter int                   KI_SHIFT   = 6,
    parameter logic [BIT_COUNT-1:0] SPEED_MIN  = BIT_COUNT'(1),
    parameter logic [BIT_COUNT-1:0] SPEED_MAX  = '1,
    parameter int                   LOCK_TOL   = 4,
    parameter int                   LOCK_COUNT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dpll_phase_filter_if.slave bus
);
    localparam int SW  = BIT_COUNT + 3;
    localparam int IW  = BIT_COUNT + 2;
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    localparam logic [ERR_W-1:0]     ERR_MAX      = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0]     TOL          = ERR_W'(LOCK_TOL);
    localparam logic [LCW-1:0]       LOCK_CNT_MAX = LCW'(LOCK_COUNT);
    localparam logic signed [SW-1:0] I_MAX        = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] I_MIN        = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};
    localparam logic signed [SW-1:0] SPD_LO       = {3'b000, SPEED_MIN};
    localparam logic signed [SW-1:0] SPD_HI       = {3'b000, SPEED_MAX};

    typedef enum logic [1:0] {IDLE, REF_LEAD, DCO_LEAD} state_t;

    state_t                  state, state_nxt;
    logic [ERR_W-1:0]        cnt, cnt_nxt;
    logic                    meas_done;
    logic signed [ERR_W-1:0] meas_err;

    logic ref_s1, ref_s2, ref_s3, dco_q;
    logic ref_rise, dco_rise;
    logic started;

    logic                    err_valid_q, locked_q;
    logic signed [ERR_W-1:0] phase_err_q;
    logic [BIT_COUNT-1:0]    speed_q;
    logic signed [IW-1:0]    integ, integ_nxt;
    logic [LCW-1:0]          lock_cnt, lock_nxt;

    logic signed [SW-1:0] err_x, p_term, i_term, integ_x, nom_x, sum, integ_sum;
    logic                 clamp_lo, clamp_hi, err_neg, err_pos, windup_hold, in_tol;
    logic [ERR_W-1:0]     err_abs;
    logic [BIT_COUNT-1:0] nom_clamp, sum_clamp;

    function automatic logic [BIT_COUNT-1:0] clamp_speed(input logic signed [SW-1:0] v);
        if (v < SPD_LO)      return SPEED_MIN;
        else if (v > SPD_HI) return SPEED_MAX;
        else                 return v[BIT_COUNT-1:0];
    endfunction

    assign ref_rise = ref_s2 & ~ref_s3;
    assign dco_rise = bus.dco_in & ~dco_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ref_rise && dco_rise) state_nxt = IDLE;
                    else if (ref_rise)        state_nxt = REF_LEAD;
                    else if (dco_rise)        state_nxt = DCO_LEAD;
                end
                REF_LEAD: if (dco_rise) state_nxt = IDLE;
                DCO_LEAD: if (ref_rise) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // A repeated leading edge closes the measurement as a cycle slip and restarts the count.
    always_comb begin
        cnt_nxt   = cnt;
        meas_done = 1'b0;
        meas_err  = '0;
        if (bus.enable) begin
            unique case (state)
                IDLE: begin
                    if (ref_rise && dco_rise) meas_done = 1'b1;
                    else if (ref_rise || dco_rise) cnt_nxt = ERR_W'(1);
                end
                REF_LEAD: begin
                    if (dco_rise || ref_rise) begin
                        meas_done = 1'b1;
                        meas_err  = $signed(cnt);
                        cnt_nxt   = ERR_W'(1);
                    end else if (cnt != ERR_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DCO_LEAD: begin
                    if (ref_rise || dco_rise) begin
                        meas_done = 1'b1;
                        meas_err  = -$signed(cnt);
                        cnt_nxt   = ERR_W'(1);
                    end else if (cnt != ERR_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    // Filter arithmetic is carried three bits wider than the tuning word so no term wraps.
    always_comb begin
        err_x     = {{(SW-ERR_W){phase_err_q[ERR_W-1]}}, phase_err_q};
        p_term    = err_x >>> KP_SHIFT;
        i_term    = err_x >>> KI_SHIFT;
        integ_x   = {{(SW-IW){integ[IW-1]}}, integ};
        nom_x     = {3'b000, bus.nominal};
        sum       = nom_x + integ_x + p_term;
        integ_sum = integ_x + i_term;
        nom_clamp = clamp_speed(nom_x);
        sum_clamp = clamp_speed(sum);

        clamp_lo    = sum < SPD_LO;
        clamp_hi    = sum > SPD_HI;
        err_neg     = phase_err_q[ERR_W-1];
        err_pos     = !phase_err_q[ERR_W-1] && (|phase_err_q);
        windup_hold = (clamp_lo && err_neg) || (clamp_hi && err_pos);

        if (windup_hold)            integ_nxt = integ;
        else if (integ_sum > I_MAX) integ_nxt = I_MAX[IW-1:0];
        else if (integ_sum < I_MIN) integ_nxt = I_MIN[IW-1:0];
        else                        integ_nxt = integ_sum[IW-1:0];

        err_abs  = err_neg ? -phase_err_q : phase_err_q;
        in_tol   = err_abs <= TOL;
        lock_nxt = (lock_cnt == LOCK_CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_s1      <= 1'b0;
            ref_s2      <= 1'b0;
            ref_s3      <= 1'b0;
            dco_q       <= 1'b0;
            started     <= 1'b0;
            err_valid_q <= 1'b0;
            phase_err_q <= '0;
            integ       <= '0;
            lock_cnt    <= '0;
            locked_q    <= 1'b0;
            speed_q     <= '0;
        end else begin
            ref_s1      <= bus.ref_in;
            ref_s2      <= ref_s1;
            ref_s3      <= ref_s2;
            dco_q       <= bus.dco_in;
            started     <= 1'b1;
            err_valid_q <= bus.enable & meas_done;
            if (bus.enable && meas_done) phase_err_q <= meas_err;

            if (!bus.enable || !started) begin
                integ    <= '0;
                lock_cnt <= '0;
                locked_q <= 1'b0;
                speed_q  <= nom_clamp;
            end else if (err_valid_q) begin
                integ   <= integ_nxt;
                speed_q <= sum_clamp;
                if (in_tol) begin
                    lock_cnt <= lock_nxt;
                    locked_q <= (lock_nxt == LOCK_CNT_MAX);
                end else begin
                    lock_cnt <= '0;
                    locked_q <= 1'b0;
                end
            end
        end
    end

    assign bus.speed_var = speed_q;
    assign bus.phase_err = phase_err_q;
    assign bus.err_valid = err_valid_q;
    assign bus.locked    = locked_q;
endmodule
